// File: rtl/porownanie_pkg.sv
// rtl/porownanie_pkg.sv - shared types and sizing helpers for the chunked comparator
package porownanie_pkg;

  typedef enum logic [2:0] {
    MODE_EQ    = 3'd0,
    MODE_NE    = 3'd1,
    MODE_LTU   = 3'd2,
    MODE_GTU   = 3'd3,
    MODE_LTS   = 3'd4,
    MODE_GTS   = 3'd5,
    MODE_GEU   = 3'd6,
    MODE_GTINV = 3'd7
  } cmp_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of chunks the operand is split into.
  function automatic int calc_nchunk(input int bits, input int chunk);
    return bits / chunk;
  endfunction

  // Width of the chunk index; never below one bit so a single-chunk build still has a register.
  function automatic int idx_width(input int nchunk);
    int w;
    w = $clog2(nchunk);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/porownanie_chunk.sv
// rtl/porownanie_chunk.sv - combinational unsigned compare of one chunk pair
module porownanie_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  // Plain magnitude compare; signed handling is done upstream by offset-binary encoding.
  always_comb begin
    gt = (a > b);
    lt = (a < b);
    eq = (a == b);
  end

endmodule

// File: rtl/porownanie_sekw.sv
// rtl/porownanie_sekw.sv - sequential MSB-first multi-mode comparator with early exit
module porownanie_sekw
  import porownanie_pkg::*;
#(
  parameter int BITS  = 32,
  parameter int CHUNK = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [BITS-1:0] i_arg_A,
  input  logic [BITS-1:0] i_arg_B,
  input  logic [2:0]      i_mode,
  output logic            o_valid,
  input  logic            i_res_ready,
  output logic            o_result
);

  localparam int NCHUNK = calc_nchunk(BITS, CHUNK);
  localparam int IW     = idx_width(NCHUNK);

  if (BITS % CHUNK != 0) begin : g_bad_width
    $error("porownanie_sekw: BITS must be a multiple of CHUNK");
  end

  state_e          state, state_n;
  logic [BITS-1:0] a_r, b_r;
  cmp_mode_e       mode_r;
  logic [IW-1:0]   idx;

  cmp_mode_e       mode_in;
  logic [BITS-1:0] a_in, b_in;
  logic [CHUNK-1:0] a_sel, b_sel;
  logic            c_gt, c_lt, c_eq;
  logic            accept, finish, res_n;

  assign o_ready = (state == ST_IDLE) && !i_rst;
  assign o_valid = (state == ST_DONE);
  assign accept  = i_valid && o_ready;
  assign finish  = (state == ST_CMP) && (!c_eq || (idx == '0));

  // Operand conditioning at accept: invert B for GTINV, flip sign bits for signed modes.
  always_comb begin
    mode_in = cmp_mode_e'(i_mode);
    a_in    = i_arg_A;
    b_in    = (mode_in == MODE_GTINV) ? ~i_arg_B : i_arg_B;
    if (mode_in == MODE_LTS || mode_in == MODE_GTS) begin
      a_in[BITS-1] = ~a_in[BITS-1];
      b_in[BITS-1] = ~b_in[BITS-1];
    end
  end

  // Select the chunk pair addressed by idx.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx == IW'(i)) begin
        a_sel = a_r[i*CHUNK +: CHUNK];
        b_sel = b_r[i*CHUNK +: CHUNK];
      end
    end
  end

  porownanie_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a  (a_sel),
    .b  (b_sel),
    .gt (c_gt),
    .lt (c_lt),
    .eq (c_eq)
  );

  // Map the deciding chunk outcome to the requested mode; c_eq here means whole operands equal.
  always_comb begin
    res_n = 1'b0;
    case (mode_r)
      MODE_EQ:                        res_n = c_eq;
      MODE_NE:                        res_n = !c_eq;
      MODE_LTU, MODE_LTS:             res_n = c_lt;
      MODE_GTU, MODE_GTS, MODE_GTINV: res_n = c_gt;
      MODE_GEU:                       res_n = c_gt | c_eq;
      default:                        res_n = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (accept) state_n = ST_CMP;
      ST_CMP:  if (finish) state_n = ST_DONE;
      ST_DONE: if (i_res_ready) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Operand capture, chunk index walk and result register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_r      <= '0;
      b_r      <= '0;
      mode_r   <= MODE_EQ;
      idx      <= '0;
      o_result <= 1'b0;
    end else begin
      if (accept) begin
        a_r    <= a_in;
        b_r    <= b_in;
        mode_r <= mode_in;
        idx    <= IW'(NCHUNK - 1);
      end else if ((state == ST_CMP) && !finish) begin
        idx <= idx - IW'(1);
      end
      if (finish) o_result <= res_n;
    end
  end

endmodule

// File: tb/tb_porownanie_sekw.sv
// tb/tb_porownanie_sekw.sv - self-checking bench for porownanie_sekw against a behavioural model
module tb_porownanie_sekw;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_arg_A;
  logic [31:0] i_arg_B;
  logic [2:0]  i_mode;
  logic        o_valid;
  logic        i_res_ready;
  logic        o_result;

  int checks   = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  porownanie_sekw #(.BITS(32), .CHUNK(8)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_arg_A     (i_arg_A),
    .i_arg_B     (i_arg_B),
    .i_mode      (i_mode),
    .o_valid     (o_valid),
    .i_res_ready (i_res_ready),
    .o_result    (o_result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_res(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m);
    case (m)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd2: return a < b;
      3'd3: return a > b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) > $signed(b);
      3'd6: return a >= b;
      default: return a > ~b;
    endcase
  endfunction

  // Chunks examined: MSB chunk down to the first one where the compared operands differ.
  function automatic int model_k(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m);
    logic [31:0] diff;
    diff = (m == 3'd7) ? (a ^ ~b) : (a ^ b);
    for (int c = 3; c >= 0; c--)
      if (diff[c*8 +: 8] != 8'h00) return 4 - c;
    return 4;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // One full operation: accept, latency, result, optional backpressure with an ignored pulse, release.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] m, input int hold);
    int  k;
    int  w;
    bit  exp_r;
    int  exp_k;
    exp_r = model_res(a, b, m);
    exp_k = model_k(a, b, m);
    w = 0;
    while (!o_ready && w < 20) begin tick(); w++; end
    chk({tag, "_ready"}, 32'(o_ready), 32'd1);
    i_arg_A = a; i_arg_B = b; i_mode = m; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    i_arg_A = $urandom; i_arg_B = $urandom; i_mode = 3'($urandom);
    k = 0;
    while (!o_valid && k < 20) begin tick(); k++; end
    chk({tag, "_lat"}, 32'(k), 32'(exp_k));
    chk({tag, "_res"}, 32'(o_result), 32'(exp_r));
    chk({tag, "_busy"}, 32'(o_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      if (h == 1) begin
        i_valid = 1'b1; i_arg_A = $urandom; i_arg_B = $urandom; i_mode = 3'($urandom);
      end else begin
        i_valid = 1'b0;
      end
      tick();
      chk({tag, "_hold_v"}, 32'(o_valid), 32'd1);
      chk({tag, "_hold_r"}, 32'(o_result), 32'(exp_r));
      chk({tag, "_hold_rdy"}, 32'(o_ready), 32'd0);
    end
    i_valid = 1'b0;
    i_res_ready = 1'b1;
    tick();
    i_res_ready = 1'b0;
    chk({tag, "_drop_v"}, 32'(o_valid), 32'd0);
    chk({tag, "_idle_rdy"}, 32'(o_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] ra, rb, mask;
    logic [2:0]  rm;
    int          sel;

    i_rst = 1'b1; i_valid = 1'b0; i_res_ready = 1'b0;
    i_arg_A = '0; i_arg_B = '0; i_mode = '0;
    tick(); tick();
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_result", 32'(o_result), 32'd0);
    i_rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(o_ready), 32'd1);

    do_op("eq_dead",   32'hDEADBEEF, 32'hDEADBEEF, 3'd0, 0);
    do_op("ne_dead",   32'hDEADBEEF, 32'hDEADBEEF, 3'd1, 0);
    do_op("gtu_msb",   32'h80000000, 32'h7FFFFFFF, 3'd3, 0);
    do_op("ltu_msb",   32'h80000000, 32'h7FFFFFFF, 3'd2, 0);
    do_op("lts_neg",   32'hFFFFFFFF, 32'h00000001, 3'd4, 0);
    do_op("ltu_neg",   32'hFFFFFFFF, 32'h00000001, 3'd2, 0);
    do_op("gts_neg",   32'hFFFFFFFF, 32'h00000001, 3'd5, 0);
    do_op("gtinv_10",  32'h00000010, 32'hFFFFFFF0, 3'd7, 0);
    do_op("gtinv_0f",  32'h0000000F, 32'hFFFFFFF0, 3'd7, 0);
    do_op("geu_eq",    32'h00000010, 32'h00000010, 3'd6, 0);
    do_op("backpress", 32'h12345678, 32'h12340000, 3'd3, 5);

    // Reset during the second CMP cycle of a full-length compare.
    i_arg_A = 32'hCAFEF00D; i_arg_B = 32'hCAFEF00D; i_mode = 3'd0; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    i_rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(o_ready), 32'd0);
    tick();
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_result", 32'(o_result), 32'd0);
    i_rst = 1'b0;
    #1;
    chk("mid_rst_rdy_after", 32'(o_ready), 32'd1);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("no_stale_valid", 32'(o_valid), 32'd0);
    end
    do_op("eq_zero", 32'h0, 32'h0, 3'd0, 0);

    for (int n = 0; n < 60; n++) begin
      ra  = $urandom;
      rm  = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 4);
      mask = (sel == 4) ? 32'h0 : (32'($urandom_range(1, 255)) << (8 * sel));
      if (rm == 3'd7) rb = ~(ra ^ mask);
      else            rb = ra ^ mask;
      if ($urandom_range(0, 3) == 0) rb = $urandom;
      do_op("rand", ra, rb, rm, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/porownanie_sekw.md
Name: porownanie_sekw

Overview:
Sequential, parametrised multi-mode comparator for the synchronous arithmetic unit. It is the successor of the combinational A-vs-B compare block. It accepts operand pairs over a valid/ready handshake and compares them MSB-first, CHUNK bits per clock, stopping early at the first differing chunk. It supports equality, unsigned, signed and inverted-B (A > ~B) modes, and returns a 1-bit result over a second valid/ready handshake.

Parameters:
BITS, 32, operand width; must be a multiple of CHUNK.
CHUNK, 8, bits compared per clock; NCHUNK = BITS/CHUNK.

Ports:
i_clk  in  1  clock; single clock domain.
i_rst  in  1  reset; synchronous, active-high.
i_valid  in  1  operands valid.
o_ready  out  1  block can accept operands.
i_arg_A  in  BITS  operand A.
i_arg_B  in  BITS  operand B.
i_mode  in  3  0 EQ, 1 NE, 2 LTU, 3 GTU, 4 LTS, 5 GTS, 6 GEU, 7 GTINV (A > ~B, unsigned).
o_valid  out  1  result valid.
i_res_ready  in  1  downstream accepts the result.
o_result  out  1  comparison result.

Behaviour:
- Reset value of every output:
  - o_valid = 0 and o_result = 0.
  - o_ready = 0 while i_rst = 1, and 1 from the first cycle after reset (state IDLE).
  - A reset in any state aborts the operation: no o_valid, no stale result.
- States: IDLE, CMP, DONE. o_ready = (state == IDLE) && !i_rst.
- Accept: on an edge with i_valid && o_ready, the block captures the operands.
  - a_r = A.
  - b_r = (mode == GTINV) ? ~B : B.
  - For LTS/GTS, the MSB of both a_r and b_r is inverted (offset-binary), which turns a signed compare into an unsigned one.
  - mode_r, idx = NCHUNK-1, flags gt = lt = 0, state -> CMP.
- CMP, each cycle compares chunk a_r[idx*CHUNK +: CHUNK] against the same chunk of b_r:
  - Chunks differ: set gt or lt, state -> DONE.
  - Chunks equal and idx == 0: operands equal, state -> DONE.
  - Otherwise: idx decrements.
- Latency: k = number of chunks examined, from the MSB chunk through the first differing chunk (NCHUNK if equal), 1 <= k <= NCHUNK.
  - o_valid rises k edges after the accept edge.
  - o_result is registered on the same edge.
- Result mapping:
  - EQ = eq; NE = !eq.
  - LTU/LTS = lt; GTU/GTS/GTINV = gt.
  - GEU = gt | eq.
- DONE:
  - o_valid = 1; o_result is held stable while i_res_ready = 0.
  - On an edge with i_res_ready = 1: o_valid -> 0 and state -> IDLE.
  - o_ready becomes 1 in the cycle after the result handshake.
- i_valid outside IDLE is ignored and the operand inputs are not sampled.
- Operand inputs may change after the accept edge without affecting the result.
- Throughput: at most one operation per k+2 cycles.
- All arithmetic is width-exact at BITS. There is no overflow path, because the comparison is purely bitwise/chunked.

Decomposition:
- Package porownanie_pkg holds:
  - typedef enum logic [2:0] cmp_mode_e (the eight modes);
  - typedef enum for the state (IDLE, CMP, DONE);
  - helper constant function for NCHUNK and the index width, $clog2(NCHUNK) with a minimum of 1.
- One sub-module, porownanie_chunk: combinational, CHUNK-wide, outputs gt/lt/eq for one chunk pair. It is instantiated once and muxed by idx.
- Elaboration-time assertion: BITS % CHUNK == 0.

Test Plan:
1. BITS=32, CHUNK=8; A=B=0xDEADBEEF, mode EQ -> o_result = 1, o_valid rises 4 edges after accept; the same operands in NE -> o_result = 0.
2. A=0x80000000, B=0x7FFFFFFF, mode GTU -> o_result = 1 with k = 1 (o_valid 1 edge after accept); mode LTU -> o_result = 0.
3. A=0xFFFFFFFF (-1), B=0x00000001, mode LTS -> o_result = 1; mode LTU -> o_result = 0; mode GTS -> o_result = 0.
4. Mode GTINV, B=0xFFFFFFF0 (~B = 0x0000000F):
   - A=0x00000010 -> o_result = 1, k = 4.
   - A=0x0000000F -> o_result = 0.
   - Mode GEU, A=B=0x00000010 -> o_result = 1.
5. Result backpressure: hold i_res_ready = 0 for 5 cycles -> o_valid = 1 and o_result stable, o_ready = 0, and an i_valid pulse with new operands is ignored. Then release -> o_valid drops, and o_ready = 1 in the next cycle.
6. Assert i_rst in the second CMP cycle -> o_valid = 0 and o_result = 0 on the next edge. After release, o_ready = 1; a fresh EQ operation (A=B=0) -> o_result = 1, with no stale result emitted.
